// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: multi-cycle fetch/execute sequencer that owns the program counter.
// It fetches a word over an imem req/ack handshake, hands it to the datapath,
// waits for ex_done, then selects the next PC (jr > jump > taken branch > pc+4).
// It also detects halt, misaligned targets and fetch timeouts.
//
// Optional feature macro: PC_SEQ_INSTRET_EN (retired-instruction counter).
//
// Ports:
//   clock, reset          rising-edge clock, async active-low reset
//   run_en                level enable for sequencing
//   imem_req/addr/ack/rdata  instruction fetch handshake (addr == pc)
//   instr, instr_valid    latched instruction word and one-cycle update pulse
//   ex_done               datapath finished current instruction
//   branch, zero, jump, jr, *_target   next-PC sources
//   halt_req              current instruction is halt
//   pc, pc_plus4          current PC and combinational pc+4
//   state                 FSM encoding (IDLE=0 FETCH=1 EXEC=2 HALTED=3 FAULT=4)
//   fault, fault_addr     sticky fault flag and offending address
//   instret               retired-instruction count (0 when feature disabled)
module pc_seq_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned IMEM_TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run_en,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        ex_done,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  input  logic        jr,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  input  logic [31:0] jr_target,
  input  logic        halt_req,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [2:0]  state,
  output logic        fault,
  output logic [31:0] fault_addr,
  output logic [31:0] instret
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_EXEC   = 3'd2,
    S_HALTED = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  state_t           cur;
  logic [CNT_W-1:0] tmo_cnt;
  logic [31:0]      next_pc;
  logic             retire;

  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;
  assign state     = cur;

  // Next-PC source select in priority order.
  always_comb begin
    next_pc = pc_plus4;
    if (jr)                next_pc = jr_target;
    else if (jump)         next_pc = jump_target;
    else if (branch && zero) next_pc = branch_target;
  end

  // An instruction retires only when it actually advances the PC.
  assign retire = (cur == S_EXEC) && ex_done && !halt_req && (next_pc[1:0] == 2'b00);

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cur         <= S_IDLE;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      instr       <= 32'h0;
      instr_valid <= 1'b0;
      fault       <= 1'b0;
      fault_addr  <= 32'h0;
      tmo_cnt     <= '0;
    end else begin
      instr_valid <= 1'b0;
      case (cur)
        S_IDLE: begin
          imem_req <= 1'b0;
          if (run_en) begin
            if (pc[1:0] != 2'b00) begin
              cur        <= S_FAULT;
              fault      <= 1'b1;
              fault_addr <= pc;
            end else begin
              cur      <= S_FETCH;
              imem_req <= 1'b1;
              tmo_cnt  <= '0;
            end
          end
        end
        S_FETCH: begin
          // Ack is checked first so it wins on the final allowed cycle.
          if (imem_ack) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            cur         <= S_EXEC;
          end else if (tmo_cnt == CNT_W'(IMEM_TIMEOUT - 1)) begin
            tmo_cnt    <= tmo_cnt + CNT_W'(1);
            imem_req   <= 1'b0;
            fault      <= 1'b1;
            fault_addr <= pc;
            cur        <= S_FAULT;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        S_EXEC: begin
          imem_req <= 1'b0;
          if (ex_done) begin
            if (halt_req) begin
              cur <= S_HALTED;
            end else if (next_pc[1:0] != 2'b00) begin
              fault      <= 1'b1;
              fault_addr <= next_pc;
              cur        <= S_FAULT;
            end else begin
              pc <= next_pc;
              if (run_en) begin
                cur      <= S_FETCH;
                imem_req <= 1'b1;
                tmo_cnt  <= '0;
              end else begin
                cur <= S_IDLE;
              end
            end
          end
        end
        S_HALTED: begin
          imem_req <= 1'b0;
        end
        S_FAULT: begin
          imem_req <= 1'b0;
          fault    <= 1'b1;
        end
        default: begin
          imem_req <= 1'b0;
          fault    <= 1'b1;
          cur      <= S_FAULT;
        end
      endcase
    end
  end

`ifdef PC_SEQ_INSTRET_EN
  logic [31:0] instret_q;

  // Retired-instruction counter, wraps modulo 2^32.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      instret_q <= 32'h0;
    end else if (retire) begin
      instret_q <= instret_q + 32'd1;
    end
  end

  assign instret = instret_q;
`else
  logic unused_retire;
  assign unused_retire = retire;
  assign instret       = 32'h0;
`endif

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Directed self-checking bench for pc_seq_ctrl (RESET_PC=0, IMEM_TIMEOUT=16).
module tb_pc_seq_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        run_en = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        ex_done = 1'b0;
  logic        branch = 1'b0;
  logic        zero = 1'b0;
  logic        jump = 1'b0;
  logic        jr = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic [31:0] jump_target = 32'h0;
  logic [31:0] jr_target = 32'h0;
  logic        halt_req = 1'b0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [2:0]  state;
  logic        fault;
  logic [31:0] fault_addr;
  logic [31:0] instret;

  int vectors = 0;
  int miscompares = 0;

`ifdef PC_SEQ_INSTRET_EN
  localparam logic [31:0] EXP_INSTRET5 = 32'd5;
`else
  localparam logic [31:0] EXP_INSTRET5 = 32'd0;
`endif

  pc_seq_ctrl #(.RESET_PC(32'h0000_0000), .IMEM_TIMEOUT(16)) dut (
    .clock(clock), .reset(reset), .run_en(run_en),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .ex_done(ex_done),
    .branch(branch), .zero(zero), .jump(jump), .jr(jr),
    .branch_target(branch_target), .jump_target(jump_target), .jr_target(jr_target),
    .halt_req(halt_req), .pc(pc), .pc_plus4(pc_plus4), .state(state),
    .fault(fault), .fault_addr(fault_addr), .instret(instret)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; run_en = 1'b0; imem_ack = 1'b0; ex_done = 1'b0;
    tick(); tick();
    reset = 1'b1;
  endtask

  task automatic fetch(input logic [31:0] w);
    imem_ack = 1'b1; imem_rdata = w;
    tick();
    imem_ack = 1'b0;
  endtask

  task automatic retire(input logic b, input logic z, input logic j, input logic r,
                        input logic h, input logic [31:0] bt, input logic [31:0] jt,
                        input logic [31:0] rt);
    branch = b; zero = z; jump = j; jr = r; halt_req = h;
    branch_target = bt; jump_target = jt; jr_target = rt; ex_done = 1'b1;
    tick();
    branch = 1'b0; zero = 1'b0; jump = 1'b0; jr = 1'b0; halt_req = 1'b0; ex_done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    vectors++; if (pc !== 32'h0) begin miscompares++; $display("FAIL rst_pc: got %h expected %h", pc, 32'h0); end
    vectors++; if (state !== 3'd0) begin miscompares++; $display("FAIL rst_state: got %0d expected 0", state); end
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL rst_req: got %b expected 0", imem_req); end
    vectors++; if (instr !== 32'h0 || instr_valid !== 1'b0) begin miscompares++; $display("FAIL rst_instr: got %h/%b expected 0/0", instr, instr_valid); end
    vectors++; if (fault !== 1'b0 || fault_addr !== 32'h0) begin miscompares++; $display("FAIL rst_fault: got %b/%h expected 0/0", fault, fault_addr); end
    vectors++; if (instret !== 32'h0) begin miscompares++; $display("FAIL rst_instret: got %h expected 0", instret); end
  endtask

  task automatic test_fetch_exec();
    do_reset();
    run_en = 1'b1;
    tick();
    vectors++; if (state !== 3'd1 || imem_req !== 1'b1) begin miscompares++; $display("FAIL fe_enter: got state %0d req %b expected 1/1", state, imem_req); end
    vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL fe_addr: got %h expected 0", imem_addr); end
    tick(); tick();
    vectors++; if (state !== 3'd1 || imem_req !== 1'b1) begin miscompares++; $display("FAIL fe_wait: got state %0d req %b expected 1/1", state, imem_req); end
    fetch(32'h2008_0005);
    vectors++; if (state !== 3'd2 || imem_req !== 1'b0) begin miscompares++; $display("FAIL fe_exec: got state %0d req %b expected 2/0", state, imem_req); end
    vectors++; if (instr !== 32'h2008_0005 || instr_valid !== 1'b1) begin miscompares++; $display("FAIL fe_instr: got %h/%b expected 20080005/1", instr, instr_valid); end
    tick();
    vectors++; if (instr_valid !== 1'b0 || state !== 3'd2 || pc !== 32'h0) begin miscompares++; $display("FAIL fe_hold: got valid %b state %0d pc %h expected 0/2/0", instr_valid, state, pc); end
    retire(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    vectors++; if (pc !== 32'h4 || state !== 3'd1) begin miscompares++; $display("FAIL fe_seq: got pc %h state %0d expected 4/1", pc, state); end
    vectors++; if (pc_plus4 !== 32'h8 || imem_req !== 1'b1) begin miscompares++; $display("FAIL fe_next: got pc4 %h req %b expected 8/1", pc_plus4, imem_req); end
  endtask

  task automatic test_branch();
    fetch(32'h1);
    retire(1, 1, 0, 0, 0, 32'h40, 32'h0, 32'h0);
    vectors++; if (pc !== 32'h40) begin miscompares++; $display("FAIL br_taken: got %h expected 40", pc); end
    fetch(32'h2);
    retire(1, 0, 0, 0, 0, 32'h80, 32'h0, 32'h0);
    vectors++; if (pc !== 32'h44) begin miscompares++; $display("FAIL br_not_taken: got %h expected 44", pc); end
    fetch(32'h3);
    retire(1, 1, 1, 1, 0, 32'h80, 32'h200, 32'h100);
    vectors++; if (pc !== 32'h100) begin miscompares++; $display("FAIL jr_prio: got %h expected 100", pc); end
    fetch(32'h4);
    retire(1, 1, 1, 0, 0, 32'h80, 32'hFFFF_FFFC, 32'h0);
    vectors++; if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin miscompares++; $display("FAIL jump: got pc %h pc4 %h expected fffffffc/0", pc, pc_plus4); end
    fetch(32'h5);
    retire(0, 0, 1, 0, 1, 32'h0, 32'h300, 32'h0);
    vectors++; if (state !== 3'd3 || pc !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL halt_prio: got state %0d pc %h expected 3/fffffffc", state, pc); end
    vectors++; if (instret !== EXP_INSTRET5) begin miscompares++; $display("FAIL instret: got %0d expected %0d", instret, EXP_INSTRET5); end
    tick(); tick();
    vectors++; if (state !== 3'd3 || imem_req !== 1'b0) begin miscompares++; $display("FAIL halted_stay: got state %0d req %b expected 3/0", state, imem_req); end
  endtask

  task automatic test_timeout();
    do_reset();
    run_en = 1'b1;
    tick();
    repeat (15) tick();
    vectors++; if (state !== 3'd1 || imem_req !== 1'b1) begin miscompares++; $display("FAIL tmo_before: got state %0d req %b expected 1/1", state, imem_req); end
    tick();
    vectors++; if (state !== 3'd4 || fault !== 1'b1) begin miscompares++; $display("FAIL tmo_fault: got state %0d fault %b expected 4/1", state, fault); end
    vectors++; if (imem_req !== 1'b0 || fault_addr !== 32'h0) begin miscompares++; $display("FAIL tmo_req: got req %b addr %h expected 0/0", imem_req, fault_addr); end
    fetch(32'hDEAD_BEEF);
    vectors++; if (state !== 3'd4 || fault !== 1'b1 || instr !== 32'h0) begin miscompares++; $display("FAIL tmo_sticky: got state %0d fault %b instr %h expected 4/1/0", state, fault, instr); end
  endtask

  task automatic test_ack_at_limit();
    do_reset();
    run_en = 1'b1;
    tick();
    repeat (15) tick();
    fetch(32'hCAFE_0001);
    vectors++; if (state !== 3'd2 || instr !== 32'hCAFE_0001 || fault !== 1'b0) begin miscompares++; $display("FAIL ack_limit: got state %0d instr %h fault %b expected 2/cafe0001/0", state, instr, fault); end
  endtask

  task automatic test_misaligned();
    retire(0, 0, 1, 0, 0, 32'h0, 32'h0000_0042, 32'h0);
    vectors++; if (state !== 3'd4 || fault !== 1'b1) begin miscompares++; $display("FAIL mis_state: got state %0d fault %b expected 4/1", state, fault); end
    vectors++; if (pc !== 32'h0 || fault_addr !== 32'h42) begin miscompares++; $display("FAIL mis_addr: got pc %h addr %h expected 0/42", pc, fault_addr); end
  endtask

  task automatic test_halt();
    do_reset();
    run_en = 1'b1;
    tick();
    fetch(32'h1);
    retire(0, 0, 1, 0, 0, 32'h0, 32'hFFFF_FFFC, 32'h0);
    fetch(32'h2);
    run_en = 1'b0;
    retire(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    vectors++; if (state !== 3'd0 || pc !== 32'h0 || imem_req !== 1'b0) begin miscompares++; $display("FAIL wrap_idle: got state %0d pc %h req %b expected 0/0/0", state, pc, imem_req); end
    run_en = 1'b1;
    tick();
    fetch(32'h3);
    retire(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    fetch(32'h4);
    retire(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    vectors++; if (pc !== 32'h8) begin miscompares++; $display("FAIL halt_pc8: got %h expected 8", pc); end
    fetch(32'hFC00_0000);
    retire(0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h0);
    vectors++; if (state !== 3'd3 || pc !== 32'h8) begin miscompares++; $display("FAIL halt: got state %0d pc %h expected 3/8", state, pc); end
    repeat (3) tick();
    vectors++; if (imem_req !== 1'b0 || state !== 3'd3) begin miscompares++; $display("FAIL halt_noreq: got req %b state %0d expected 0/3", imem_req, state); end
  endtask

  task automatic test_async_reset();
    do_reset();
    run_en = 1'b1;
    tick();
    fetch(32'h1);
    retire(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    vectors++; if (pc !== 32'h4 || imem_req !== 1'b1) begin miscompares++; $display("FAIL ar_pre: got pc %h req %b expected 4/1", pc, imem_req); end
    #3;
    reset = 1'b0;
    #1;
    vectors++; if (imem_req !== 1'b0 || pc !== 32'h0 || state !== 3'd0) begin miscompares++; $display("FAIL ar_now: got req %b pc %h state %0d expected 0/0/0", imem_req, pc, state); end
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    tick();
    reset = 1'b1; imem_ack = 1'b0; run_en = 1'b0;
    tick();
    vectors++; if (state !== 3'd0 || instr !== 32'h0 || instr_valid !== 1'b0) begin miscompares++; $display("FAIL ar_ack_ignored: got state %0d instr %h valid %b expected 0/0/0", state, instr, instr_valid); end
  endtask

  initial begin
    test_reset();
    test_fetch_exec();
    test_branch();
    test_timeout();
    test_ack_at_limit();
    test_misaligned();
    test_halt();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
